count_rom_stage: RTL
====================

Name: count_rom_stage

Overview:
- Downstream consumer of the 3-bit counter's count output.
- Detects each new count value and looks it up in an 8-entry x 8-bit ROM (3-to-8 decode table by default).
- Queues the looked-up word in a small FIFO and presents it on a valid/ready output interface.
- Lets the slower display/output logic consume one word per count change without losing events, and flags any events it does lose.

Parameters:
- DEPTH, 2: FIFO depth in entries; power of two, minimum 2.
- DW, 8: ROM word width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- count  in  3  counter value, used as the ROM address.
- count_en  in  1  when 1, count is sampled for change detection; when 0, count is ignored and prev_count holds.
- out_ready  in  1  consumer accepts data_out this cycle.
- out_valid  out  1  data_out and addr_out are valid.
- data_out  out  DW  ROM word for the queued address.
- addr_out  out  3  count value that produced data_out.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset==0 at the clock edge):
  - out_valid=0, data_out=0, addr_out=0, overflow=0, level=0.
  - FIFO flushed; prev_count=0; primed=0.
  - Reset has priority over every other input, including mid-transfer. An entry presented but not yet popped is discarded.
- Event generation, combinational in cycle t: evt = count_en & (~primed | (count != prev_count)).
  - At each edge with count_en=1: prev_count <= count, primed <= 1.
  - The first enabled sample after reset always produces an event, even if count==0.
- Lookup: ROM is a constant table; default entry i = 1<<i (3-to-8 one-hot). On evt, push {count, ROM[count]} into the FIFO at the same edge.
- Latency: count changes before edge N → push at edge N → out_valid=1 after edge N, when the FIFO was empty. There is no combinational path from count to out_valid.
- Output handshake:
  - A pop occurs when out_valid & out_ready at the edge.
  - data_out and addr_out come from the FIFO head and are registered.
  - data_out and addr_out hold stable while out_valid=1 and out_ready=0.
  - out_valid = (level != 0).
- Full FIFO:
  - If evt, level==DEPTH and no pop this edge: the event is dropped and overflow <= 1.
  - If evt, level==DEPTH and a pop happens on the same edge: the push succeeds, level stays at DEPTH, no overflow.
- Empty FIFO: out_ready is ignored; no pop, no underflow.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, order preserved (FIFO order).
- overflow: set has priority over clr_ovf on the same edge; otherwise clr_ovf=1 clears it.
- Wrap-around: count 7→0 is an ordinary change and produces an event with address 0.
- count held constant: no events. Reloading the same value after count_en toggles does not produce an event (prev_count retained).

Decomposition:
- Package count_rom_pkg holds:
  - ADDR_W=3 and DW_DEFAULT=8;
  - typedef rom_word_t (logic [DW-1:0]);
  - typedef entry_t (struct: addr[2:0], data);
  - constant ROM_TABLE[0:7] with the default one-hot contents.
- One sub-module, sync_fifo: parameterised on width/depth, synchronous active-low reset, push/pop/full/empty/level.
- Change detection, ROM lookup and the overflow flag live in the top module.

Test Plan:
- Reset, then count_en=1, count=0 held → one event; out_valid=1 one cycle later with data_out=8'h01, addr_out=0. No further events while count stays 0.
- count steps 3→4→5 with out_ready=1 → output sequence 8'h08, 8'h10, 8'h20, each 1 cycle after its change; level never exceeds 1.
- out_ready=0, count steps 1,2,3,4 (DEPTH=2):
  - after 1 and 2: level=2, data_out=8'h02 held stable;
  - after 3: overflow=1;
  - then out_ready=1 drains 8'h02, 8'h04;
  - the 3 and 4 events are not delivered;
  - clr_ovf clears overflow.
- FIFO full, out_ready=1 on the same edge as a new count → push accepted, level stays 2, overflow stays 0.
- Wrap: count 6→7→0 with out_ready=1 → 8'h40, 8'h80, 8'h01 (addr_out 6, 7, 0).
- reset=0 asserted while level=2 and out_valid=1 → next cycle out_valid=0, level=0, overflow=0. After release, the first enabled sample produces an event again.

Source files
------------

// File: rtl/count_rom_pkg.sv
// Shared types and constants for the count-to-ROM lookup stage.
package count_rom_pkg;

   localparam int ADDR_W     = 3;
   localparam int DW_DEFAULT = 8;

   typedef logic [DW_DEFAULT-1:0] rom_word_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      rom_word_t         data;
   } entry_t;

   // Default contents: 3-to-8 one-hot decode.
   localparam rom_word_t ROM_TABLE [0:7] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
   };

   function automatic rom_word_t rom_lookup(input logic [ADDR_W-1:0] addr);
      return ROM_TABLE[addr];
   endfunction

endpackage

// File: rtl/count_rom_stage_if.sv
// Counter-input and valid/ready output bundle of count_rom_stage.
interface count_rom_stage_if #(
   parameter int DW    = 8,
   parameter int DEPTH = 2
);
   import count_rom_pkg::*;

   logic [ADDR_W-1:0]       count;
   logic                    count_en;
   logic                    out_ready;
   logic                    clr_ovf;
   logic                    out_valid;
   logic [DW-1:0]           data_out;
   logic [ADDR_W-1:0]       addr_out;
   logic                    overflow;
   logic [$clog2(DEPTH):0]  level;

   modport master (
      output count, count_en, out_ready, clr_ovf,
      input  out_valid, data_out, addr_out, overflow, level
   );

   modport slave (
      input  count, count_en, out_ready, clr_ovf,
      output out_valid, data_out, addr_out, overflow, level
   );
endinterface

// File: rtl/count_rom_stage_sync_fifo.sv
// Small show-ahead FIFO: the head entry sits in a register so that the
// consumer sees registered data with one cycle from push to valid.
module sync_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [LW-1:0] level_r;
   logic [W-1:0]  head_r;
   logic          valid_r;

   logic          wr_en_s;
   logic          rd_en_s;
   logic          full_s;
   logic [AW-1:0] rd_ptr_nxt_s;
   logic [LW-1:0] level_nxt_s;
   logic [W-1:0]  head_nxt_s;

   // Push/pop qualification, next occupancy and next head word.
   always_comb begin
      full_s       = (level_r == LW'(DEPTH));
      rd_en_s      = pop & valid_r;
      wr_en_s      = push & (~full_s | rd_en_s);
      rd_ptr_nxt_s = rd_en_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   level_nxt_s = level_r + LW'(1);
         2'b01:   level_nxt_s = level_r - LW'(1);
         default: level_nxt_s = level_r;
      endcase
      // A word written this edge into the next head slot bypasses the array.
      if (level_nxt_s == LW'(0)) begin
         head_nxt_s = head_r;
      end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_nxt_s = din;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Storage, pointers, occupancy and registered head.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
         head_r   <= {W{1'b0}};
         valid_r  <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         level_r  <= level_nxt_s;
         head_r   <= head_nxt_s;
         valid_r  <= (level_nxt_s != LW'(0));
      end
   end

   assign dout  = head_r;
   assign valid = valid_r;
   assign full  = full_s;
   assign level = level_r;

endmodule

// File: rtl/count_rom_stage.sv
// Turns every change of the counter value into one queued ROM word on a
// valid/ready port; events that find the queue full are dropped and flagged.
module count_rom_stage
   import count_rom_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 8
) (
   input  logic               clk,
   input  logic               reset,
   count_rom_stage_if.slave   bus
);
   localparam int W = ADDR_W + DW;

   logic [ADDR_W-1:0] prev_r;
   logic              primed_r;
   logic              ovf_r;

   logic              evt_s;
   logic              drop_s;
   logic              full_s;
   logic              valid_s;
   logic [W-1:0]      entry_s;
   logic [W-1:0]      head_s;

   // Change detection; the first enabled sample after reset always counts.
   always_comb begin
      evt_s  = 1'b0;
      drop_s = 1'b0;
      if (bus.count_en) begin
         evt_s = ~primed_r | (bus.count != prev_r);
      end else begin
         evt_s = 1'b0;
      end
      // A pop on the same edge frees the slot, so only a non-popping full queue drops.
      drop_s  = evt_s & full_s & ~(valid_s & bus.out_ready);
      entry_s = {bus.count, DW'(rom_lookup(bus.count))};
   end

   // Last sampled count; held while sampling is disabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_r   <= {ADDR_W{1'b0}};
         primed_r <= 1'b0;
      end else if (bus.count_en) begin
         prev_r   <= bus.count;
         primed_r <= 1'b1;
      end else begin
         prev_r   <= prev_r;
         primed_r <= primed_r;
      end
   end

   // Sticky overflow; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_r <= 1'b0;
      end else if (drop_s) begin
         ovf_r <= 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (evt_s),
      .pop   (bus.out_ready),
      .din   (entry_s),
      .dout  (head_s),
      .valid (valid_s),
      .full  (full_s),
      .level (bus.level)
   );

   assign bus.out_valid = valid_s;
   assign bus.data_out  = head_s[DW-1:0];
   assign bus.addr_out  = head_s[W-1:DW];
   assign bus.overflow  = ovf_r;

endmodule
